// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, E/M pipeline-register layouts and ALU operation codes.
// Pure declarations with no latency. There is no backpressure here.
package y86_pkg;

    localparam int WORD_W = 64;
    localparam int REG_W  = 4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam int E_W          = 217;
    localparam int E_STAT       = 216;
    localparam int E_ICODE_LSB  = 212;
    localparam int E_IFUN_LSB   = 208;
    localparam int E_VALC_LSB   = 144;
    localparam int E_VALA_LSB   = 80;
    localparam int E_VALB_LSB   = 16;
    localparam int E_DSTE_LSB   = 12;
    localparam int E_DSTM_LSB   = 8;
    localparam int E_SRCA_LSB   = 4;
    localparam int E_SRCB_LSB   = 0;

    localparam int M_W          = 145;
    localparam int M_STAT       = 144;
    localparam int M_ICODE_LSB  = 140;
    localparam int M_CND        = 139;
    localparam int M_VALE_LSB   = 75;
    localparam int M_VALA_LSB   = 11;
    localparam int M_DSTE_LSB   = 7;
    localparam int M_DSTM_LSB   = 3;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_XOR,
        ALU_ZERO
    } alu_op_e;

    typedef struct packed {
        logic              stat;
        logic [REG_W-1:0]  icode;
        logic [REG_W-1:0]  ifun;
        logic [WORD_W-1:0] val_c;
        logic [WORD_W-1:0] val_a;
        logic [WORD_W-1:0] val_b;
        logic [REG_W-1:0]  dst_e;
        logic [REG_W-1:0]  dst_m;
        logic [REG_W-1:0]  src_a;
        logic [REG_W-1:0]  src_b;
    } e_reg_t;

    typedef struct packed {
        logic              stat;
        logic [REG_W-1:0]  icode;
        logic              cnd;
        logic [WORD_W-1:0] val_e;
        logic [WORD_W-1:0] val_a;
        logic [REG_W-1:0]  dst_e;
        logic [REG_W-1:0]  dst_m;
        logic [2:0]        rsvd;
    } m_reg_t;

    function automatic m_reg_t m_bubble();
        m_reg_t b;
        b       = '0;
        b.icode = I_NOP;
        b.dst_e = RNONE;
        b.dst_m = RNONE;
        return b;
    endfunction

endpackage

// File: rtl/y86_execute_stage_if.sv
// Decode->execute->memory bundle: E register and stall flags in, forwarding and M register out.
// No storage, so no latency. There is no backpressure; the pipeline advances every clock.
interface y86_execute_stage_if;
    logic [216:0] exec_rgstr;
    logic         W_stat;
    logic         m_stat;
    logic [63:0]  e_valE;
    logic [3:0]   e_dstE;
    logic [144:0] M;

    modport slave (
        input  exec_rgstr,
        input  W_stat,
        input  m_stat,
        output e_valE,
        output e_dstE,
        output M
    );

    modport master (
        output exec_rgstr,
        output W_stat,
        output m_stat,
        input  e_valE,
        input  e_dstE,
        input  M
    );
endinterface

// File: rtl/y86_alu.sv
// 64-bit Y86 ALU computing b op a, with zero/sign/overflow flags for the result.
// Purely combinational with zero latency. It has no backpressure.
module y86_alu
    import y86_pkg::*;
(
    input  logic [WORD_W-1:0] alu_a,
    input  logic [WORD_W-1:0] alu_b,
    input  alu_op_e           alu_op,
    output logic [WORD_W-1:0] alu_res,
    output logic              alu_zf,
    output logic              alu_sf,
    output logic              alu_of
);

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        unique case (alu_op)
            ALU_ADD: begin
                alu_res = alu_b + alu_a;
                alu_of  = (alu_a[WORD_W-1] == alu_b[WORD_W-1]) &&
                          (alu_res[WORD_W-1] != alu_b[WORD_W-1]);
            end
            ALU_SUB: begin
                alu_res = alu_b - alu_a;
                alu_of  = (alu_a[WORD_W-1] != alu_b[WORD_W-1]) &&
                          (alu_res[WORD_W-1] != alu_b[WORD_W-1]);
            end
            ALU_AND: alu_res = alu_b & alu_a;
            ALU_XOR: alu_res = alu_b ^ alu_a;
            default: alu_res = '0;
        endcase
        alu_zf = (alu_res == '0);
        alu_sf = alu_res[WORD_W-1];
    end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, cnd, forwarding, M register (EXEC_CC_PORT_EN exposes cc_out).
// e_valE/e_dstE have zero latency; M and CC update one clk after E.
// There is no backpressure; a new E register is accepted every clk.
module y86_execute_stage
    import y86_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    y86_execute_stage_if.slave   ex
`ifdef EXEC_CC_PORT_EN
    ,
    output logic [2:0]           cc_out
`endif
);

    e_reg_t            e;
    logic [WORD_W-1:0] alu_a;
    logic [WORD_W-1:0] alu_b;
    alu_op_e           alu_op;
    logic [WORD_W-1:0] alu_res;
    logic              alu_zf;
    logic              alu_sf;
    logic              alu_of;
    logic [2:0]        cc_q;
    logic [2:0]        cc_d;
    logic              cc_zf;
    logic              cc_sf;
    logic              cc_of;
    logic              cnd;
    logic [REG_W-1:0]  dst_e;
    m_reg_t            m_q;
    m_reg_t            m_d;
    logic              unused_src;

    assign e          = e_reg_t'(ex.exec_rgstr);
    assign unused_src = ^{e.src_a, e.src_b};

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ZERO;
        unique case (e.icode)
            I_OPQ: begin
                alu_a = e.val_a;
                alu_b = e.val_b;
                unique case (e.ifun)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_XOR:   alu_op = ALU_XOR;
                    default: alu_op = ALU_ZERO;
                endcase
            end
            I_RRMOVQ: begin
                alu_a  = e.val_a;
                alu_op = ALU_ADD;
            end
            I_IRMOVQ: begin
                alu_a  = e.val_c;
                alu_op = ALU_ADD;
            end
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a  = e.val_c;
                alu_b  = e.val_b;
                alu_op = ALU_ADD;
            end
            I_PUSHQ, I_CALL: begin
                alu_a  = 64'd8;
                alu_b  = e.val_b;
                alu_op = ALU_SUB;
            end
            I_POPQ, I_RET: begin
                alu_a  = 64'd8;
                alu_b  = e.val_b;
                alu_op = ALU_ADD;
            end
            default: alu_op = ALU_ZERO;
        endcase
    end

    y86_alu u_alu (
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_res (alu_res),
        .alu_zf  (alu_zf),
        .alu_sf  (alu_sf),
        .alu_of  (alu_of)
    );

    assign cc_zf = cc_q[2];
    assign cc_sf = cc_q[1];
    assign cc_of = cc_q[0];

    // cnd looks at the flags before this instruction's own update.
    always_comb begin
        cnd = 1'b0;
        if (e.icode == I_RRMOVQ || e.icode == I_JXX) begin
            unique case (e.ifun)
                C_ALWAYS: cnd = 1'b1;
                C_LE:     cnd = (cc_sf ^ cc_of) | cc_zf;
                C_L:      cnd = cc_sf ^ cc_of;
                C_E:      cnd = cc_zf;
                C_NE:     cnd = ~cc_zf;
                C_GE:     cnd = ~(cc_sf ^ cc_of);
                C_G:      cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
                default:  cnd = 1'b0;
            endcase
        end
    end

    // An exception anywhere downstream freezes CC so the faulting state stays architectural.
    always_comb begin
        cc_d = cc_q;
        if (e.icode == I_OPQ && !e.stat && !ex.m_stat && !ex.W_stat) begin
            cc_d = {alu_zf, alu_sf, alu_of};
        end
    end

    assign dst_e = (e.icode == I_RRMOVQ && !cnd) ? RNONE : e.dst_e;

    always_comb begin
        m_d       = '0;
        m_d.stat  = e.stat;
        m_d.icode = e.icode;
        m_d.cnd   = cnd;
        m_d.val_e = alu_res;
        m_d.val_a = e.val_a;
        m_d.dst_e = dst_e;
        m_d.dst_m = e.dst_m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
            m_q  <= m_bubble();
        end else begin
            cc_q <= cc_d;
            m_q  <= m_d;
        end
    end

    assign ex.e_valE = alu_res;
    assign ex.e_dstE = dst_e;
    assign ex.M      = m_q;

`ifdef EXEC_CC_PORT_EN
    assign cc_out = cc_q;
`endif

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed vector bench for y86_execute_stage: per-vector forwarding, M register and CC checks.
module tb_y86_execute_stage;
    import y86_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    y86_execute_stage_if ex_if();
    logic [2:0] cc_obs;

`ifdef EXEC_CC_PORT_EN
    logic [2:0] cc_out;
    y86_execute_stage dut (.clk(clk), .rst_n(rst_n), .ex(ex_if), .cc_out(cc_out));
    assign cc_obs = cc_out;
`else
    y86_execute_stage dut (.clk(clk), .rst_n(rst_n), .ex(ex_if));
    assign cc_obs = dut.cc_q;
`endif

    m_reg_t m_obs;
    assign m_obs = m_reg_t'(ex_if.M);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] val_c;
        logic [63:0] val_a;
        logic [63:0] val_b;
        logic [3:0]  dst_e;
        logic        m_st;
        logic        w_st;
        logic [63:0] x_val_e;
        logic [3:0]  x_dst_e;
        logic        x_cnd;
        logic [2:0]  x_cc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                                input logic [3:0] de, input logic ms, input logic ws,
                                input logic [63:0] xe, input logic [3:0] xd, input logic xc,
                                input logic [2:0] xcc);
        vec_t v;
        v.stat = st; v.icode = ic; v.ifun = fn; v.val_c = vc; v.val_a = va; v.val_b = vb;
        v.dst_e = de; v.m_st = ms; v.w_st = ws;
        v.x_val_e = xe; v.x_dst_e = xd; v.x_cnd = xc; v.x_cc = xcc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        e_reg_t er;
        er       = '0;
        er.stat  = v.stat;
        er.icode = v.icode;
        er.ifun  = v.ifun;
        er.val_c = v.val_c;
        er.val_a = v.val_a;
        er.val_b = v.val_b;
        er.dst_e = v.dst_e;
        er.dst_m = 4'hF;
        er.src_a = 4'hF;
        er.src_b = 4'hF;
        ex_if.exec_rgstr = er;
        ex_if.m_stat     = v.m_st;
        ex_if.W_stat     = v.w_st;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, " M.icode"}, 64'(m_obs.icode), 64'h1);
        check({tag, " M.stat"},  64'(m_obs.stat),  64'h0);
        check({tag, " M.cnd"},   64'(m_obs.cnd),   64'h0);
        check({tag, " M.valE"},  m_obs.val_e,      64'h0);
        check({tag, " M.valA"},  m_obs.val_a,      64'h0);
        check({tag, " M.dstE"},  64'(m_obs.dst_e), 64'hF);
        check({tag, " M.dstM"},  64'(m_obs.dst_m), 64'hF);
        check({tag, " CC"},      64'(cc_obs),      64'h4);
    endtask

    localparam logic [63:0] MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINNEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        vec_t v;
        //            st icode    ifun     valC     valA     valB     dstE m  w  valE      dstE cnd cc
        vecs.push_back(mk(0, I_OPQ,    F_ADD,   0,       5,       7,       3, 0, 0, 12,       3, 0, 3'b000));
        vecs.push_back(mk(0, I_RRMOVQ, C_LE,    0,       'h55,    0,       2, 0, 0, 'h55,     4'hF, 0, 3'b000));
        vecs.push_back(mk(0, I_OPQ,    F_SUB,   0,       7,       7,       4, 0, 0, 0,        4, 0, 3'b100));
        vecs.push_back(mk(0, I_RRMOVQ, C_LE,    0,       'h55,    0,       2, 0, 0, 'h55,     2, 1, 3'b100));
        vecs.push_back(mk(0, I_OPQ,    F_SUB,   0,       1,       0,       4, 0, 0, ALL1,     4, 0, 3'b010));
        vecs.push_back(mk(0, I_JXX,    C_L,     'h40,    0,       0,       4'hF, 0, 0, 0,     4'hF, 1, 3'b010));
        vecs.push_back(mk(0, I_OPQ,    F_SUB,   0,       1,       MINNEG,  4, 0, 0, MAXPOS,   4, 0, 3'b001));
        vecs.push_back(mk(0, I_JXX,    C_GE,    'h40,    0,       0,       4'hF, 0, 0, 0,     4'hF, 0, 3'b001));
        vecs.push_back(mk(0, I_PUSHQ,  0,       0,       'h77,    'h100,   4, 0, 0, 'hF8,     4, 0, 3'b001));
        vecs.push_back(mk(0, I_POPQ,   0,       0,       'hF8,    'hF8,    4, 0, 0, 'h100,    4, 0, 3'b001));
        vecs.push_back(mk(0, I_MRMOVQ, 0,       'h10,    0,       'h20,    4'hF, 0, 0, 'h30,  4'hF, 0, 3'b001));
        vecs.push_back(mk(0, I_OPQ,    F_ADD,   0,       1,       2,       3, 1, 0, 3,        3, 0, 3'b001));
        vecs.push_back(mk(0, I_OPQ,    F_ADD,   0,       0,       0,       3, 0, 1, 0,        3, 0, 3'b001));
        vecs.push_back(mk(0, I_OPQ,    F_ADD,   0,       MAXPOS,  1,       3, 0, 0, MINNEG,   3, 0, 3'b011));
        vecs.push_back(mk(0, I_OPQ,    F_AND,   0,       'hF0,    'h0F,    3, 0, 0, 0,        3, 0, 3'b100));
        vecs.push_back(mk(0, I_OPQ,    F_XOR,   0,       'hFF,    'h0F,    3, 0, 0, 'hF0,     3, 0, 3'b000));
        vecs.push_back(mk(0, I_HALT,   0,       0,       9,       9,       4'hF, 0, 0, 0,     4'hF, 0, 3'b000));
        vecs.push_back(mk(0, I_IRMOVQ, 0,       'h1234,  0,       0,       5, 0, 0, 'h1234,   5, 0, 3'b000));
        vecs.push_back(mk(0, I_RRMOVQ, C_ALWAYS,0,       'hABC,   0,       6, 0, 0, 'hABC,    6, 1, 3'b000));
        vecs.push_back(mk(0, I_JXX,    4'h7,    'h40,    0,       0,       4'hF, 0, 0, 0,     4'hF, 0, 3'b000));
        vecs.push_back(mk(0, I_RRMOVQ, C_G,     0,       'h11,    0,       7, 0, 0, 'h11,     7, 1, 3'b000));
        vecs.push_back(mk(1, I_OPQ,    F_ADD,   0,       1,       1,       3, 0, 0, 2,        3, 0, 3'b000));
        vecs.push_back(mk(0, I_CALL,   0,       'h500,   0,       'h200,   4, 0, 0, 'h1F8,    4, 0, 3'b000));
        vecs.push_back(mk(0, I_RET,    0,       0,       'h1F8,   'h1F8,   4, 0, 0, 'h200,    4, 0, 3'b000));
        vecs.push_back(mk(0, I_RRMOVQ, C_NE,    0,       'h22,    0,       8, 0, 0, 'h22,     8, 1, 3'b000));
        vecs.push_back(mk(0, I_RMMOVQ, 0,       8,       'h99,    'h100,   4'hF, 0, 0, 'h108, 4'hF, 0, 3'b000));

        // Asynchronous reset takes effect before any clock edge.
        rst_n = 1'b1;
        drive(vecs[0]);
        #1 rst_n = 1'b0;
        #1 check_bubble("reset");
        @(posedge clk); #1;
        check_bubble("reset held");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            drive(v);
            #1;
            check($sformatf("v%0d e_valE", i), ex_if.e_valE,        v.x_val_e);
            check($sformatf("v%0d e_dstE", i), 64'(ex_if.e_dstE),   64'(v.x_dst_e));
            @(posedge clk); #1;
            check($sformatf("v%0d M.stat", i),  64'(m_obs.stat),    64'(v.stat));
            check($sformatf("v%0d M.icode", i), 64'(m_obs.icode),   64'(v.icode));
            check($sformatf("v%0d M.cnd", i),   64'(m_obs.cnd),     64'(v.x_cnd));
            check($sformatf("v%0d M.valE", i),  m_obs.val_e,        v.x_val_e);
            check($sformatf("v%0d M.valA", i),  m_obs.val_a,        v.val_a);
            check($sformatf("v%0d M.dstE", i),  64'(m_obs.dst_e),   64'(v.x_dst_e));
            check($sformatf("v%0d M.dstM", i),  64'(m_obs.dst_m),   64'hF);
            check($sformatf("v%0d M.rsvd", i),  64'(m_obs.rsvd),    64'h0);
            check($sformatf("v%0d CC", i),      64'(cc_obs),        64'(v.x_cc));
        end

        // Mid-cycle reset after real traffic, held over an edge, then released.
        @(negedge clk);
        drive(vecs[0]);
        #2 rst_n = 1'b0;
        #1 check_bubble("midreset");
        @(posedge clk); #1;
        check_bubble("midreset held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset M.valE", m_obs.val_e,       64'd12);
        check("post-reset M.dstE", 64'(m_obs.dst_e),  64'h3);
        check("post-reset CC",     64'(cc_obs),       64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
